// File: rtl/bp_pkg.sv
// Branch-predictor shared types: the resolved-branch record exchanged between EX,
// the update queue and the BHT, plus a saturating-counter helper.
package bp_pkg;

    localparam int BP_PC_W = 32;

    typedef struct packed {
        logic [BP_PC_W-1:0] pc;
        logic               taken;
        logic               pred;
    } bp_upd_t;

    // True while a w-bit counter holding v still has room to count up (w <= 32).
    function automatic logic bp_can_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] lim;
        lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return v != lim;
    endfunction

endpackage

// File: rtl/bht_update_queue_if.sv
// EX-side record handshake and BHT-side update port of the branch update queue.
interface bht_update_queue_if #(
    parameter int PC_W = 32
);
    logic            ex_valid;
    logic [PC_W-1:0] ex_pc;
    logic            ex_taken;
    logic            ex_pred;
    logic            ex_ready;
    logic            upd_ready;
    logic            update;
    logic [PC_W-1:0] PC_update;
    logic            BR;

    modport master (
        output ex_valid, ex_pc, ex_taken, ex_pred, upd_ready,
        input  ex_ready, update, PC_update, BR
    );

    modport slave (
        input  ex_valid, ex_pc, ex_taken, ex_pred, upd_ready,
        output ex_ready, update, PC_update, BR
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO: storage, wrapping pointers and an occupancy count one bit wider
// than the pointers. The data output is the head entry, or the last popped one when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] last_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign last_ptr = rd_ptr - PTR_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is defined solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? mem[last_ptr] : mem[rd_ptr];

endmodule

// File: rtl/bht_update_queue.sv
// Queues resolved branches from EX and drains one per cycle into the BHT update port,
// dropping records on overflow and keeping saturating applied/mispredict/drop counts.
module bht_update_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = BP_PC_W,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    bht_update_queue_if.slave      bus,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [CNT_W-1:0]       br_cnt,
    output logic [CNT_W-1:0]       miss_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);

    localparam int REC_W = $bits(bp_upd_t);

    bp_upd_t wr_rec;
    bp_upd_t head;
    logic    full;
    logic    empty;
    logic    push;
    logic    pop;
    logic    drop;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return v + CNT_W'(bp_can_inc(32'(v), CNT_W));
    endfunction

    assign wr_rec = '{pc: BP_PC_W'(bus.ex_pc), taken: bus.ex_taken, pred: bus.ex_pred};

    // Acceptance depends only on stored state, so a same-cycle pop never frees a full queue.
    assign push = bus.ex_valid & ~full;
    assign drop = bus.ex_valid & full;
    assign pop  = ~empty & bus.upd_ready;

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (wr_rec),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (occupancy)
    );

    assign bus.ex_ready  = ~full;
    assign bus.update    = pop;
    assign bus.PC_update = PC_W'(head.pc);
    assign bus.BR        = head.taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            br_cnt   <= '0;
            miss_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (pop) begin
                br_cnt <= sat_inc(br_cnt);
                if (head.pred != head.taken) miss_cnt <= sat_inc(miss_cnt);
            end
            if (drop) drop_cnt <= sat_inc(drop_cnt);
        end
    end

endmodule

// File: tb/tb_bht_update_queue.sv
// Scoreboard bench for bht_update_queue: a queue-based reference model drives expectations,
// a negedge monitor checks every cycle; a CNT_W=2 twin shares the stimulus for saturation.
module tb_bht_update_queue;
    import bp_pkg::*;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CNT_W = 16;
    localparam int SAT_W = 2;
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bht_update_queue_if #(.PC_W(PC_W)) mif ();
    bht_update_queue_if #(.PC_W(PC_W)) sif ();

    logic [OCC_W-1:0] occ, occ2;
    logic [CNT_W-1:0] br, miss, drop;
    logic [SAT_W-1:0] br2, miss2, drop2;

    bht_update_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(mif.slave),
        .occupancy(occ), .br_cnt(br), .miss_cnt(miss), .drop_cnt(drop)
    );

    bht_update_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst(rst), .bus(sif.slave),
        .occupancy(occ2), .br_cnt(br2), .miss_cnt(miss2), .drop_cnt(drop2)
    );

    assign sif.ex_valid  = mif.ex_valid;
    assign sif.ex_pc     = mif.ex_pc;
    assign sif.ex_taken  = mif.ex_taken;
    assign sif.ex_pred   = mif.ex_pred;
    assign sif.upd_ready = mif.upd_ready;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic            pred;
    } rec_t;

    rec_t mq[$];
    rec_t sb[$];
    int   n_br, n_miss, n_drop;
    logic cur_u;
    bit   mon_en = 0;
    int   compared = 0;
    int   mismatched = 0;

    function automatic longint sat(input int n, input int w);
        longint lim;
        lim = (longint'(1) << w) - 1;
        return (n > lim) ? lim : longint'(n);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model advances right after the edge.
    task automatic step(input logic v, input logic [PC_W-1:0] pc, input logic t,
                        input logic p, input logic u);
        rec_t r;
        bit   was_full;
        mif.ex_valid  = v;
        mif.ex_pc     = pc;
        mif.ex_taken  = t;
        mif.ex_pred   = p;
        mif.upd_ready = u;
        cur_u         = u;
        @(posedge clk);
        was_full = (mq.size() == DEPTH);
        if (mq.size() != 0 && u) begin
            r = mq.pop_front();
            n_br++;
            if (r.taken != r.pred) n_miss++;
        end
        if (v) begin
            if (was_full) n_drop++;
            else begin
                r = '{pc, t, p};
                mq.push_back(r);
                sb.push_back(r);
            end
        end
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        sb.delete();
        n_br = 0;
        n_miss = 0;
        n_drop = 0;
    endtask

    initial begin : monitor
        rec_t r;
        logic exp_upd;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                exp_upd = (mq.size() != 0) && cur_u;
                chk("ex_ready", mif.ex_ready, mq.size() != DEPTH);
                chk("occupancy", occ, mq.size());
                chk("update", mif.update, exp_upd);
                if (mif.update) begin
                    if (sb.size() == 0) chk("update_unexpected", 1, 0);
                    else begin
                        r = sb.pop_front();
                        chk("PC_update", mif.PC_update, r.pc);
                        chk("BR", mif.BR, r.taken);
                    end
                end
                chk("br_cnt", br, sat(n_br, CNT_W));
                chk("miss_cnt", miss, sat(n_miss, CNT_W));
                chk("drop_cnt", drop, sat(n_drop, CNT_W));
                chk("sat_update", sif.update, exp_upd);
                chk("sat_occupancy", occ2, mq.size());
                chk("sat_ready", sif.ex_ready, mq.size() != DEPTH);
                if (sif.update) chk("sat_pc", sif.PC_update, mif.PC_update);
                if (sif.update) chk("sat_br_out", sif.BR, mif.BR);
                chk("sat_br_cnt", br2, sat(n_br, SAT_W));
                chk("sat_miss_cnt", miss2, sat(n_miss, SAT_W));
                chk("sat_drop_cnt", drop2, sat(n_drop, SAT_W));
            end
        end
    end

    initial begin : stimulus
        logic [PC_W-1:0] pc;
        logic t;
        model_reset();
        mif.ex_valid = 1'b0; mif.ex_pc = '0; mif.ex_taken = 1'b0;
        mif.ex_pred = 1'b0; mif.upd_ready = 1'b0; cur_u = 1'b0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_ex_ready", mif.ex_ready, 1);
        chk("rst_update", mif.update, 0);
        chk("rst_occ", occ, 0);
        chk("rst_counts", {br, miss, drop}, 0);
        mon_en = 1;
        repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Single push, mispredicted
        step(1'b1, 32'h0000_0040, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("single_br", br, 1);
        chk("single_miss", miss, 1);
        chk("empty_hold_pc", mif.PC_update, 32'h40);

        // Fill and overflow, then drain
        for (int i = 0; i < 5; i++) step(1'b1, 32'h100 + 32'(i) * 4, i[0], 1'b1, 1'b0);
        chk("overflow_drop", drop, 1);
        repeat (5) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) step(1'b1, 32'h200 + 32'(i) * 4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h2FC, 1'b1, 1'b1, 1'b1);
        chk("fullpp_occ", occ, 3);
        chk("fullpp_drop", drop, 2);
        repeat (4) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Streaming with wrap
        for (int i = 0; i < 20; i++) begin
            t = 1'($urandom);
            step(1'b1, 32'h1000 + 32'(i) * 4, t, 1'($urandom), 1'b1);
        end
        chk("stream_drop", drop, 2);
        repeat (2) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Mid-operation reset with three entries queued
        for (int i = 0; i < 3; i++) step(1'b1, 32'h3000 + 32'(i), 1'b1, 1'b0, 1'b0);
        mif.ex_valid = 1'b0;
        mif.upd_ready = 1'b1;
        #1 rst = 1'b0;
        #1;
        chk("midrst_update", mif.update, 0);
        chk("midrst_occ", occ, 0);
        chk("midrst_counts", {br, miss, drop}, 0);
        chk("midrst_sat_counts", {br2, miss2, drop2}, 0);
        model_reset();
        cur_u = 1'b1;
        #1 rst = 1'b1;
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Saturation of the 2-bit twin
        for (int i = 0; i < 5; i++) step(1'b1, 32'h4000 + 32'(i) * 4, 1'b1, 1'b0, 1'b1);
        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("sat_br_hold", br2, 3);
        chk("sat_miss_hold", miss2, 3);
        chk("wide_br", br, 5);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            pc = $urandom;
            t  = 1'($urandom);
            step($urandom_range(0, 3) != 0, pc, t,
                 ($urandom_range(0, 2) == 0) ? ~t : t, $urandom_range(0, 2) != 0);
        end
        repeat (DEPTH + 1) step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("final_sb_empty", sb.size(), 0);

        mon_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
